// File: rtl/dsc_slice_sched_if.sv
// Slice command channel from the DSC slice scheduler to the slice encoder.
interface dsc_slice_sched_if #(
  parameter int DIM_W = 16,
  parameter int IDX_W = 12
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_x;
  logic [DIM_W-1:0] cmd_y;
  logic [DIM_W-1:0] cmd_w;
  logic [DIM_W-1:0] cmd_h;
  logic [DIM_W+2:0] cmd_chunk;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_last;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_chunk, cmd_idx, cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_chunk, cmd_idx, cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/dsc_slice_sched.sv
// DSC slice scheduler: walks the picture in raster slice order, issues one
// command per slice under a credit limit, and reports picture completion.
module dsc_slice_sched #(
  parameter int DIM_W           = 16,
  parameter int BPP_W           = 10,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IDX_W           = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] pic_w,
  input  logic [DIM_W-1:0] pic_h,
  input  logic [DIM_W-1:0] slice_width,
  input  logic [DIM_W-1:0] slice_height,
  input  logic [BPP_W-1:0] bits_per_pixel,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic             slice_done,
  output logic             unexp_done,
  dsc_slice_sched_if.master cmd
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PROD_W = DIM_W + BPP_W;
  localparam int CHK_W  = DIM_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] pw_q, pw_d, ph_q, ph_d, sw_q, sw_d, sh_q, sh_d;
  logic [BPP_W-1:0] bpp_q, bpp_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             done_q, done_d, cfg_err_q, cfg_err_d, unexp_q, unexp_d;

  logic [DIM_W:0]    x_nxt, y_nxt;
  logic [DIM_W-1:0]  rem_w, rem_h, w_c, h_c;
  logic [PROD_W-1:0] prod;
  logic [CHK_W-1:0]  chunk_c;
  logic              x_end, y_end, last_c, credit_ok, valid_c, hs, bad_cfg;

  // Sums carry one extra bit so x+slice_width cannot wrap past pic_w.
  always_comb begin
    x_nxt     = {1'b0, x_q} + {1'b0, sw_q};
    y_nxt     = {1'b0, y_q} + {1'b0, sh_q};
    x_end     = x_nxt >= {1'b0, pw_q};
    y_end     = y_nxt >= {1'b0, ph_q};
    last_c    = x_end && y_end;
    rem_w     = pw_q - x_q;
    rem_h     = ph_q - y_q;
    w_c       = (sw_q < rem_w) ? sw_q : rem_w;
    h_c       = (sh_q < rem_h) ? sh_q : rem_h;
    prod      = PROD_W'(w_c) * PROD_W'(bpp_q);
    // bpp is in 1/16 units and chunk is in bytes: divide by 128, rounding up.
    chunk_c   = CHK_W'(prod[PROD_W-1:7]) + CHK_W'(|prod[6:0]);
    credit_ok = out_q < CNT_W'(MAX_OUTSTANDING);
    valid_c   = (state_q == S_ISSUE) && credit_ok;
    hs        = valid_c && cmd.cmd_ready;
    bad_cfg   = (pw_q == '0) || (ph_q == '0) || (sw_q == '0) || (sh_q == '0) ||
                (bpp_q == '0) || (sw_q > pw_q) || (sh_q > ph_q);
  end

  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    ph_d      = ph_q;
    sw_d      = sw_q;
    sh_d      = sh_q;
    bpp_d     = bpp_q;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pw_d    = pic_w;
          ph_d    = pic_h;
          sw_d    = slice_width;
          sh_d    = slice_height;
          bpp_d   = bits_per_pixel;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_cfg) begin
          cfg_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (x_end) begin
            x_d = '0;
            y_d = y_nxt[DIM_W-1:0];
          end else begin
            x_d = x_nxt[DIM_W-1:0];
          end
          if (last_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Credit counter runs in every state so stray completions are always flagged.
  always_comb begin
    out_d   = out_q;
    unexp_d = 1'b0;
    if (hs && !slice_done) begin
      out_d = out_q + CNT_W'(1);
    end else if (!hs && slice_done) begin
      if (out_q == '0) unexp_d = 1'b1;
      else             out_d   = out_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pw_q      <= '0;
      ph_q      <= '0;
      sw_q      <= '0;
      sh_q      <= '0;
      bpp_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pw_q      <= pw_d;
      ph_q      <= ph_d;
      sw_q      <= sw_d;
      sh_q      <= sh_d;
      bpp_q     <= bpp_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      unexp_q   <= unexp_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign unexp_done    = unexp_q;
  assign cmd.cmd_valid = valid_c;
  assign cmd.cmd_x     = x_q;
  assign cmd.cmd_y     = y_q;
  assign cmd.cmd_w     = w_c;
  assign cmd.cmd_h     = h_c;
  assign cmd.cmd_chunk = chunk_c;
  assign cmd.cmd_idx   = idx_q;
  assign cmd.cmd_last  = (state_q == S_ISSUE) && last_c;

endmodule

// File: tb/tb_dsc_slice_sched.sv
// Scoreboard bench for dsc_slice_sched: stimulus pushes expected commands,
// a monitor pops and compares them on every handshake.
module tb_dsc_slice_sched;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic [18:0] chunk;
    logic [11:0] idx;
    logic        last;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pic_w, pic_h, slice_width, slice_height;
  logic [9:0]  bits_per_pixel;
  logic        busy, done, cfg_err, unexp_done;
  logic        auto_sd, man_sd, auto_en;
  logic        slice_done;

  cmd_t sb[$];
  int   checks;
  int   failures;
  int   hs_count;
  int   done_cnt;

  assign slice_done = auto_sd | man_sd;

  dsc_slice_sched_if #(.DIM_W(16), .IDX_W(12)) cmd_if ();

  dsc_slice_sched #(
    .DIM_W(16), .BPP_W(10), .MAX_OUTSTANDING(2), .IDX_W(12)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .pic_w(pic_w), .pic_h(pic_h),
    .slice_width(slice_width), .slice_height(slice_height),
    .bits_per_pixel(bits_per_pixel),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .slice_done(slice_done), .unexp_done(unexp_done),
    .cmd(cmd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input int x, input int y, input int w, input int h,
                               input int c, input int idx, input bit last);
    cmd_t e;
    e.x = 16'(x); e.y = 16'(y); e.w = 16'(w); e.h = 16'(h);
    e.chunk = 19'(c); e.idx = 12'(idx); e.last = last;
    sb.push_back(e);
  endfunction

  function automatic cmd_t cur_cmd();
    cmd_t g;
    g.x = cmd_if.cmd_x; g.y = cmd_if.cmd_y; g.w = cmd_if.cmd_w; g.h = cmd_if.cmd_h;
    g.chunk = cmd_if.cmd_chunk; g.idx = cmd_if.cmd_idx; g.last = cmd_if.cmd_last;
    return g;
  endfunction

  // Monitor: every accepted command is matched against the scoreboard head.
  initial begin : monitor
    cmd_t g, e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        hs_count++;
        g = cur_cmd();
        if (sb.size() == 0) begin
          chk("cmd_unexpected", 128'(g), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("cmd_fields", 128'(g), 128'(e));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Encoder model: returns slice_done three cycles after each accepted command.
  initial begin : responder
    logic [2:0] dl;
    dl = '0;
    auto_sd = 1'b0;
    forever begin
      @(negedge clk);
      dl = {dl[1:0], auto_en && cmd_if.cmd_valid && cmd_if.cmd_ready};
      @(posedge clk);
      #1 auto_sd = dl[2];
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pic(input int pw, input int ph, input int sw, input int sh, input int bpp);
    @(posedge clk);
    #1;
    pic_w = 16'(pw); pic_h = 16'(ph);
    slice_width = 16'(sw); slice_height = 16'(sh);
    bits_per_pixel = 10'(bpp);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    int d0;
    seen = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(seen), 128'(1));
    chk("busy_at_done", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("done_once", 128'(done_cnt - d0), 128'(1));
    chk("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic pulse_sd(input int n);
    @(posedge clk);
    #1 man_sd = 1'b1;
    repeat (n) @(posedge clk);
    #1 man_sd = 1'b0;
  endtask

  int pc1_x[6] = '{0, 64, 0, 64, 0, 64};
  int pc1_y[6] = '{0, 0, 4, 4, 8, 8};
  int pc1_w[6] = '{64, 36, 64, 36, 64, 36};
  int pc1_h[6] = '{4, 4, 4, 4, 2, 2};
  int pc1_c[6] = '{100, 57, 100, 57, 100, 57};

  initial begin : stim
    cmd_t held;
    bit   found;
    int   d0;
    checks = 0; failures = 0; hs_count = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; man_sd = 1'b0; auto_en = 1'b0;
    pic_w = '0; pic_h = '0; slice_width = '0; slice_height = '0; bits_per_pixel = '0;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 128'({busy, done, cfg_err, unexp_done, cmd_if.cmd_valid, cmd_if.cmd_last}), 128'(0));
    chk("rst_fields", 128'(cur_cmd()), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_if.cmd_ready = 1'b1;

    // slice_done with nothing outstanding while idle
    pulse_sd(1);
    @(negedge clk);
    chk("unexp_pulse", 128'(unexp_done), 128'(1));
    @(negedge clk);
    chk("unexp_clear", 128'(unexp_done), 128'(0));

    // zero slice width is rejected
    start_pic(1920, 1080, 0, 108, 128);
    @(negedge clk);
    chk("cfgerr_t1", 128'({busy, cfg_err, cmd_if.cmd_valid}), 128'(3'b100));
    @(negedge clk);
    chk("cfgerr_t2", 128'({busy, cfg_err, cmd_if.cmd_valid}), 128'(3'b010));
    @(negedge clk);
    chk("cfgerr_t3", 128'({busy, cfg_err, cmd_if.cmd_valid}), 128'(3'b000));

    // nominal 1920x1080, 960x108 slices, 8.0 bpp
    for (int i = 0; i < 20; i++) push((i % 2) * 960, (i / 2) * 108, 960, 108, 960, i, i == 19);
    auto_en = 1'b1;
    start_pic(1920, 1080, 960, 108, 128);
    @(negedge clk);
    chk("nom_check_state", 128'({busy, cmd_if.cmd_valid}), 128'(2'b10));
    @(negedge clk);
    chk("nom_first_valid", 128'({busy, cmd_if.cmd_valid}), 128'(2'b11));
    wait_done(600);

    // clipping with fractional rate
    for (int i = 0; i < 6; i++) push(pc1_x[i], pc1_y[i], pc1_w[i], pc1_h[i], pc1_c[i], i, i == 5);
    start_pic(100, 10, 64, 4, 200);
    wait_done(300);

    // credit limit
    auto_en = 1'b0;
    hs_count = 0;
    for (int i = 0; i < 8; i++) push((i % 4) * 16, (i / 4) * 4, 16, 4, 16, i, i == 7);
    start_pic(64, 8, 16, 4, 128);
    repeat (10) @(negedge clk);
    chk("credit_hs2", 128'(hs_count), 128'(2));
    chk("credit_stall", 128'(cmd_if.cmd_valid), 128'(0));
    @(posedge clk);
    #1 cmd_if.cmd_ready = 1'b0;
    pulse_sd(1);
    @(negedge clk);
    chk("credit_return", 128'(cmd_if.cmd_valid), 128'(1));
    @(posedge clk);
    #1 begin cmd_if.cmd_ready = 1'b1; man_sd = 1'b1; end
    @(posedge clk);
    #1 man_sd = 1'b0;
    @(negedge clk);
    chk("coincident_keep", 128'(cmd_if.cmd_valid), 128'(1));
    @(negedge clk);
    chk("coincident_full", 128'(cmd_if.cmd_valid), 128'(0));
    chk("credit_hs4", 128'(hs_count), 128'(4));
    auto_en = 1'b1;
    pulse_sd(2);
    wait_done(300);

    // backpressure on idx 3
    for (int i = 0; i < 6; i++) push(pc1_x[i], pc1_y[i], pc1_w[i], pc1_h[i], pc1_c[i], i, i == 5);
    start_pic(100, 10, 64, 4, 200);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_if.cmd_valid && cmd_if.cmd_ready && cmd_if.cmd_idx == 12'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_reach_idx2", 128'(found), 128'(1));
    @(posedge clk);
    #1 cmd_if.cmd_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_if.cmd_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_valid", 128'(found), 128'(1));
    held = cur_cmd();
    push(0, 0, 0, 0, 0, 0, 0);
    chk("bp_idx3_fields", 128'(held), 128'(sb[0]));
    void'(sb.pop_back());
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 128'({cmd_if.cmd_valid, cur_cmd()}), 128'({1'b1, held}));
    end
    @(posedge clk);
    #1 cmd_if.cmd_ready = 1'b1;
    wait_done(300);

    // reset after three issued commands
    hs_count = 0;
    for (int i = 0; i < 20; i++) push((i % 2) * 960, (i / 2) * 108, 960, 108, 960, i, i == 19);
    start_pic(1920, 1080, 960, 108, 128);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (hs_count == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_hs3", 128'(found), 128'(1));
    cmd_if.cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ctrl", 128'({busy, done, cfg_err, unexp_done, cmd_if.cmd_valid, cmd_if.cmd_last}), 128'(0));
    chk("rstmid_fields", 128'(cur_cmd()), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    auto_en = 1'b0;
    sb.delete();
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("rstmid_no_done", 128'(done_cnt - d0), 128'(0));
    chk("rstmid_idle", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
